// File: rtl/rho_rotate_func_pkg.sv
`default_nettype none
// ============================================================================
// Module : rho_rotate_func_pkg
// Purpose: Shared geometry, FSM encoding and rho offset table for the Keccak
//          rho stage. The offset table is also used by the inverse path.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package rho_rotate_func_pkg;

  localparam int SLICES  = 64;  // z slices per state (lane width)
  localparam int SLICE_W = 25;  // bits per slice, bit i = x + 5*y
  localparam int ADDR_W  = 6;   // log2(SLICES)

  localparam logic [ADDR_W-1:0] LAST_SLICE = ADDR_W'(SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_FIN  = 2'd3
  } rho_state_e;

  // Rotation offset per lane, indexed by i = x + 5*y.
  localparam logic [ADDR_W-1:0] RHO_OFF [SLICE_W] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,   // y = 0
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,   // y = 1
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,   // y = 2
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,    // y = 3
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14    // y = 4
  };

endpackage
`default_nettype wire

// File: rtl/rho_rotate_func_slice_mux.sv
`default_nettype none
// ============================================================================
// Module : rho_slice_mux
// Purpose: Combinational rotated-slice selector. Output bit i of slice z is
//          taken from buffered slice (z - r_i) mod 64, bit i.
// Ports  : buf_flat  in  SLICES*SLICE_W  whole buffered state, slice s at
//                                         bits [s*SLICE_W +: SLICE_W]
//          z         in  ADDR_W          output slice index
//          slice_out out SLICE_W         rotated slice z
// Rev    : 1.0  initial release
// ============================================================================
module rho_slice_mux
  import rho_rotate_func_pkg::*;
(
  input  logic [SLICES*SLICE_W-1:0] buf_flat,
  input  logic [ADDR_W-1:0]         z,
  output logic [SLICE_W-1:0]        slice_out
);

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    logic [SLICES-1:0] lane;
    logic [ADDR_W-1:0] src;

    // Gather lane i along z so each output bit is one 64:1 mux.
    for (genvar s = 0; s < SLICES; s++) begin : g_lane
      assign lane[s] = buf_flat[s*SLICE_W + i];
    end

    // 6-bit subtraction wraps naturally, giving (z - r) mod 64.
    assign src          = z - RHO_OFF[i];
    assign slice_out[i] = lane[src];
  end

endmodule
`default_nettype wire

// File: rtl/rho_rotate_func.sv
`default_nettype none
// ============================================================================
// Module : rho_rotate_func
// Purpose: Keccak rho stage. Loads a 5x5x64 state slice by slice from a
//          source memory, then writes out 64 slices with every lane rotated
//          along z by its rho offset.
// Ports  : clk, rst (async, active high), start (launch on rising edge)
//          rd_addr/line_in      source memory read (combinational read)
//          write_enable/_addr/_value  destination slice write
//          busy (LOAD through EMIT), done (one-cycle end-of-run pulse)
// Rev    : 1.0  initial release
// ============================================================================
module rho_rotate_func
  import rho_rotate_func_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [SLICE_W-1:0] line_in,
  output logic               write_enable,
  output logic [ADDR_W-1:0]  write_addr,
  output logic [SLICE_W-1:0] write_value,
  output logic               busy,
  output logic               done
);

  rho_state_e                state;
  logic                      start_d;
  logic [ADDR_W-1:0]         z_cnt;
  logic [SLICE_W-1:0]        slice_buf [SLICES];
  logic [SLICES*SLICE_W-1:0] buf_flat;
  logic [SLICE_W-1:0]        rot_slice;

  // Buffer contents need no reset: every run overwrites all entries first.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      slice_buf[rd_addr] <= line_in;
    end
  end

  for (genvar s = 0; s < SLICES; s++) begin : g_flat
    assign buf_flat[s*SLICE_W +: SLICE_W] = slice_buf[s];
  end

  rho_slice_mux u_slice_mux (
    .buf_flat  (buf_flat),
    .z         (z_cnt),
    .slice_out (rot_slice)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      start_d      <= 1'b0;
      rd_addr      <= '0;
      z_cnt        <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_value  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_d <= start;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          rd_addr <= '0;
          z_cnt   <= '0;
          // Only a fresh rising edge launches; edges in other states are dropped.
          if (start && !start_d) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          rd_addr <= rd_addr + ADDR_W'(1);
          if (rd_addr == LAST_SLICE) begin
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          write_enable <= 1'b1;
          write_addr   <= z_cnt;
          write_value  <= rot_slice;
          z_cnt        <= z_cnt + ADDR_W'(1);
          if (z_cnt == LAST_SLICE) begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          write_enable <= 1'b0;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rho_rotate_func.sv
`default_nettype none
// ============================================================================
// Module : tb_rho_rotate_func
// Purpose: Self-checking bench for rho_rotate_func. Expected slices come from
//          a lane-rotation reference model and are queued per run, then
//          popped as the DUT writes.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_rho_rotate_func;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  rd_addr;
  logic [24:0] line_in;
  logic        write_enable;
  logic [5:0]  write_addr;
  logic [24:0] write_value;
  logic        busy;
  logic        done;

  logic [24:0] mem [64];
  assign line_in = mem[rd_addr];

  rho_rotate_func dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rd_addr      (rd_addr),
    .line_in      (line_in),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_value  (write_value),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int rho_tb [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                      41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  function automatic logic [63:0] rotl(input logic [63:0] v, input int r);
    return (v << r) | (v >> (64 - r));
  endfunction

  // Scoreboard entries: {write_addr, write_value}
  logic [30:0] sb_q [$];
  logic [30:0] mon_e;
  int we_count, first_we, done_cyc, done_count;

  always @(negedge clk) begin
    if (write_enable) begin
      if (we_count == 0) first_we = cyc;
      we_count++;
      if (sb_q.size() == 0) begin
        check_val("unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("write_addr", 64'(write_addr), 64'(mon_e[30:25]));
        check_val("write_value", 64'(write_value), 64'(mon_e[24:0]));
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic push_expected();
    logic [63:0] lane;
    logic [63:0] rl;
    logic [24:0] sl [64];
    for (int i = 0; i < 25; i++) begin
      for (int z = 0; z < 64; z++) lane[z] = mem[z][i];
      rl = rotl(lane, rho_tb[i]);
      for (int z = 0; z < 64; z++) sl[z][i] = rl[z];
    end
    for (int z = 0; z < 64; z++) sb_q.push_back({6'(z), sl[z]});
  endtask

  // Reference theta on the lane view of mem.
  task automatic apply_theta();
    logic [63:0] a [25];
    logic [63:0] c [5];
    logic [63:0] d [5];
    for (int i = 0; i < 25; i++)
      for (int z = 0; z < 64; z++) a[i][z] = mem[z][i];
    for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
    for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
    for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
    for (int i = 0; i < 25; i++)
      for (int z = 0; z < 64; z++) mem[z][i] = a[i][z];
  endtask

  task automatic clear_counts();
    we_count = 0; done_count = 0; first_we = -1; done_cyc = -1;
  endtask

  task automatic run_full(input string name, input bit hold_start);
    int e0;
    clear_counts();
    push_expected();
    @(posedge clk); #1;
    start = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 300 && done_count == 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_val({name, "_done_count"}, 64'(done_count), 64'd1);
    check_val({name, "_done_lat"}, 64'(done_cyc - e0), 64'd129);
    check_val({name, "_first_we_lat"}, 64'(first_we - e0), 64'd65);
    check_val({name, "_we_count"}, 64'(we_count), 64'd64);
    check_val({name, "_sb_left"}, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    if (!hold_start) start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int z = 0; z < 64; z++) mem[z] = '0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_we", 64'(write_enable), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_rd_addr", 64'(rd_addr), 64'd0);
    check_val("rst_write_addr", 64'(write_addr), 64'd0);
    check_val("rst_write_value", 64'(write_value), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single bit in lane (1,0)
    mem[0][1] = 1'b1;
    run_full("single_bit", 1'b0);

    // Lane (0,0) offset 0 and lane (4,4) offset 14
    for (int z = 0; z < 64; z++) mem[z] = '0;
    mem[5][0]   = 1'b1;
    mem[60][24] = 1'b1;
    run_full("lane_pair", 1'b0);

    // All ones / all zeros
    for (int z = 0; z < 64; z++) mem[z] = 25'h1FFFFFF;
    run_full("all_ones", 1'b0);
    for (int z = 0; z < 64; z++) mem[z] = '0;
    run_full("all_zero", 1'b0);

    // Reset partway through LOAD
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1;
    repeat (31) @(posedge clk);
    #1;
    check_val("mid_busy_before_rst", 64'(busy), 64'd1);
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check_val("mid_rst_we", 64'(write_enable), 64'd0);
    check_val("mid_rst_done", 64'(done), 64'd0);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (140) @(posedge clk);
    #1;
    check_val("mid_rst_no_done", 64'(done_count), 64'd0);
    check_val("mid_rst_no_we", 64'(we_count), 64'd0);
    run_full("after_rst", 1'b0);

    // start held high: one run only, then a fresh edge gives an identical run
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    run_full("hold_run1", 1'b1);
    clear_counts();
    repeat (150) @(posedge clk);
    #1;
    check_val("hold_no_relaunch_we", 64'(we_count), 64'd0);
    check_val("hold_no_relaunch_done", 64'(done_count), 64'd0);
    start = 1'b0;
    @(posedge clk);
    run_full("hold_run2", 1'b0);

    // Theta then rho on a random state
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    apply_theta();
    run_full("chain", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
